// File: rtl/noc_params.sv
// Shared NoC link types: virtual-channel count, flit labels and flit layout.
package noc_params;

   localparam int unsigned VC_NUM     = 4;
   localparam int unsigned FLIT_DATA_W = 16;

   typedef enum logic [1:0] {
      FLIT_HEAD     = 2'd0,
      FLIT_BODY     = 2'd1,
      FLIT_TAIL     = 2'd2,
      FLIT_HEADTAIL = 2'd3
   } flit_label_t;

   typedef struct packed {
      flit_label_t            label;
      logic [FLIT_DATA_W-1:0] data;
   } flit_t;

   // True for labels that close a packet.
   function automatic logic is_tail(input flit_label_t label);
      return (label == FLIT_TAIL) || (label == FLIT_HEADTAIL);
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin priority search: first set request bit strictly after ptr,
// wrapping N-1 -> 0, with ptr itself searched last.
module rr_arbiter #(
   parameter int unsigned N = 4
) (
   input  logic [N-1:0]         request,
   input  logic [$clog2(N)-1:0] ptr,
   output logic [N-1:0]         grant
);

   localparam int unsigned PW = $clog2(N);

   int unsigned   idx;
   logic [PW-1:0] sel;
   logic          found;

   // Walk the N candidates in priority order and keep only the first hit.
   always_comb begin
      grant = '0;
      found = 1'b0;
      idx   = 0;
      sel   = '0;
      for (int unsigned i = 1; i <= N; i++) begin
         idx = (32'(ptr) + i) % N;
         sel = PW'(idx);
         if (!found && request[sel]) begin
            grant[sel] = 1'b1;
            found      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/output_link_scheduler.sv
// Output link scheduler: arbitrates VC flits onto one link with packet
// locking (no interleaving), a registered link stage and a stall watchdog.
module output_link_scheduler
   import noc_params::*;
#(
   parameter int unsigned VC_NUM    = noc_params::VC_NUM,
   parameter int unsigned STALL_MAX = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [VC_NUM-1:0]    req_i,
   input  flit_t [VC_NUM-1:0]   flit_i,
   input  logic [VC_NUM-1:0]    tail_i,
   input  logic [VC_NUM-1:0]    on_off_i,
   output logic [VC_NUM-1:0]    grant_o,
   output flit_t                data_o,
   output logic                 valid_o,
   output logic [VC_NUM-1:0]    lock_o,
   output logic                 error_o
);

   localparam int unsigned PW = $clog2(VC_NUM);
   localparam int unsigned CW = $clog2(STALL_MAX + 1);
   localparam logic [CW-1:0] STALL_CNT = CW'(STALL_MAX);

   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } state_t;

   state_t        state;
   logic [PW-1:0] owner;
   logic [PW-1:0] ptr;
   logic [CW-1:0] stall_cnt;

   logic [VC_NUM-1:0] eligible;
   logic [VC_NUM-1:0] owner_mask;
   logic [VC_NUM-1:0] arb_req;
   logic [VC_NUM-1:0] arb_grant;
   logic [PW-1:0]     gidx;
   logic              granted;

   // While locked the arbiter sees only the owner, so the same search
   // serves both states and the owner is the only possible winner.
   always_comb begin
      eligible   = req_i & on_off_i;
      owner_mask = '0;
      owner_mask[owner] = 1'b1;
      arb_req    = (state == LOCKED) ? (eligible & owner_mask) : eligible;
   end

   rr_arbiter #(
      .N (VC_NUM)
   ) u_rr_arbiter (
      .request (arb_req),
      .ptr     (ptr),
      .grant   (arb_grant)
   );

   // Grant is suppressed during reset; encode the one-hot winner to an index.
   always_comb begin
      grant_o = rst ? '0 : arb_grant;
      granted = |arb_grant;
      gidx    = '0;
      for (int unsigned i = 0; i < VC_NUM; i++) begin
         if (arb_grant[i]) gidx = PW'(i);
      end
   end

   // Lock FSM, round-robin pointer, link register and stall watchdog.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         owner     <= '0;
         ptr       <= PW'(VC_NUM - 1);
         stall_cnt <= '0;
         valid_o   <= 1'b0;
         data_o    <= '0;
         error_o   <= 1'b0;
         lock_o    <= '0;
      end else begin
         error_o <= error_o | (stall_cnt == STALL_CNT);
         if (granted) begin
            ptr       <= gidx;
            data_o    <= flit_i[gidx];
            valid_o   <= 1'b1;
            stall_cnt <= '0;
            case (state)
               IDLE: begin
                  if (!tail_i[gidx]) begin
                     state  <= LOCKED;
                     owner  <= gidx;
                     lock_o <= arb_grant;
                  end
               end
               LOCKED: begin
                  if (tail_i[gidx]) begin
                     state  <= IDLE;
                     lock_o <= '0;
                  end
               end
               default: begin
                  state  <= IDLE;
                  lock_o <= '0;
               end
            endcase
         end else begin
            valid_o <= 1'b0;
            if (state == LOCKED) begin
               if (stall_cnt != STALL_CNT) stall_cnt <= stall_cnt + CW'(1);
            end else begin
               stall_cnt <= '0;
            end
         end
      end
   end

endmodule

// File: doc/output_link_scheduler.md
OUTPUT_LINK_SCHEDULER -- requirements
Module: output_link_scheduler

Interface
REQ-001 Parameter VC_NUM, default noc_params::VC_NUM, number of virtual channels sharing one output link (>=2).
REQ-002 Parameter STALL_MAX, default 16, count of consecutive stalled LOCKED cycles that raises error_o (>=1).
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 req_i  input  VC_NUM  bit v=1: VC v presents a valid flit on flit_i[v].
REQ-006 flit_i  input  flit_t [VC_NUM-1:0]  candidate flit per VC.
REQ-007 tail_i  input  VC_NUM  bit v=1: flit_i[v] is TAIL or HEADTAIL.
REQ-008 on_off_i  input  VC_NUM  bit v=1: downstream VC v can accept a flit.
REQ-009 grant_o  output  VC_NUM  combinational, one-hot or zero; pops VC v this cycle.
REQ-010 data_o  output  flit_t  registered link flit.
REQ-011 valid_o  output  1  registered; data_o valid.
REQ-012 lock_o  output  VC_NUM  one-hot owner while LOCKED, else zero.
REQ-013 error_o  output  1  sticky stall-watchdog flag.

Function
REQ-014 VC v is eligible iff req_i[v] & on_off_i[v].
REQ-015 FSM states IDLE and LOCKED; owner register holds the locked VC index.
REQ-016 IDLE: grant the first eligible VC searching round-robin from ptr+1 upward, wrapping VC_NUM-1 -> 0; no eligible VC -> grant_o = 0.
REQ-017 IDLE grant with tail_i=0 -> LOCKED, owner = granted VC; with tail_i=1 (HEADTAIL) -> stay IDLE.
REQ-018 LOCKED: only owner is grantable; other VCs blocked regardless of eligibility (no flit interleaving on the link).
REQ-019 LOCKED grant with tail_i[owner]=1 -> IDLE next cycle; otherwise stay LOCKED.
REQ-020 ptr updates to the granted VC index on every grant; unchanged otherwise.
REQ-021 On grant to v: next cycle data_o = flit_i[v], valid_o = 1 (latency 1); without grant: valid_o = 0, data_o holds last value.
REQ-022 Stall counter, width $clog2(STALL_MAX+1): increments each LOCKED cycle with no grant, saturates at STALL_MAX, clears on any grant or on entering IDLE.
REQ-023 error_o sets the cycle after the counter reaches STALL_MAX; remains 1 until reset; does not alter arbitration.
REQ-024 Owner losing on_off_i or req_i mid-packet: no grant, lock held, counter advances.
REQ-025 Request and tail on the owner in the same cycle as on_off_i high: grant and unlock in that cycle's transition; the new arbitration starts next cycle.

Reset
REQ-026 rst=1 forces IDLE, owner=0, ptr=VC_NUM-1 (VC 0 has first priority), counter=0, valid_o=0, data_o=0, error_o=0, lock_o=0.
REQ-027 rst mid-packet drops the lock immediately; grant_o is 0 while rst=1.

Structure
REQ-028 flit_t, VC_NUM and the flit label enum live in noc_params; STALL_MAX stays a module parameter.
REQ-029 The round-robin priority search is one sub-module, rr_arbiter (request, ptr -> one-hot grant), instantiated once.

Verification (VC_NUM=4, STALL_MAX=4)
REQ-030 After reset, req_i=4'b1111, on_off_i=4'b1111, all tail_i=1 -> grants VC0,1,2,3,0 on consecutive cycles; valid_o=1 from cycle 2.
REQ-031 VC2 head (tail=0) granted, then req_i=4'b1111 for 3 cycles, VC2 tail on the 3rd -> only VC2 granted, lock_o=4'b0100 throughout, next grant goes to VC3.
REQ-032 LOCKED on VC1 with on_off_i[1]=0 for 5 cycles -> no grants, error_o=1 after the 4th stalled cycle and stays 1 after the packet completes.
REQ-033 Only VC3 requesting, HEADTAIL every cycle -> grant every cycle, state stays IDLE, ptr wraps 3 -> 3, data_o tracks flit_i[3] one cycle late.
REQ-034 rst pulsed while LOCKED on VC2 -> all outputs zero; after release with req_i=4'b0101, VC0 is granted first.
